// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, counter type and 9-bit RGB field layout.
// Pure declarations: no latency, no flow control.
package vga_scanout_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Pixel word is {red, green, blue}, three bits each.
  localparam int CHAN_W  = 3;
  localparam int RED_LSB = 6;
  localparam int GRN_LSB = 3;
  localparam int BLU_LSB = 0;

  // Sync fields are active-high here so a cleared pipeline means "not in sync".
  typedef struct packed {
    logic active;
    logic hsync_on;
    logic vsync_on;
    logic frame_start;
  } vid_ctl_t;

  function automatic logic in_span(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus raw active/sync/frame-start flags decoded from the current count.
// Flags are combinational from the counter flops; free-running, no backpressure.
module vga_timing #(
  parameter int H_ACTIVE = vga_scanout_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_scanout_pkg::H_FRONT,
  parameter int H_SYNC   = vga_scanout_pkg::H_SYNC,
  parameter int H_BACK   = vga_scanout_pkg::H_BACK,
  parameter int V_ACTIVE = vga_scanout_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_scanout_pkg::V_FRONT,
  parameter int V_SYNC   = vga_scanout_pkg::V_SYNC,
  parameter int V_BACK   = vga_scanout_pkg::V_BACK
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  output vga_scanout_pkg::cnt_t      o_h_count,
  output vga_scanout_pkg::cnt_t      o_v_count,
  output vga_scanout_pkg::vid_ctl_t  o_ctl
);
  import vga_scanout_pkg::*;

  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SSTRT = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t H_SEND  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t H_LAST  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SSTRT = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t V_SEND  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam cnt_t V_LAST  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    o_ctl             = '0;
    o_ctl.active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    o_ctl.hsync_on    = in_span(h_cnt_q, H_SSTRT, H_SEND);
    o_ctl.vsync_on    = in_span(v_cnt_q, V_SSTRT, V_SEND);
    o_ctl.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign o_h_count = h_cnt_q;
  assign o_v_count = v_cnt_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: requests tile/local pixel coordinates, latches renderer RGB, drives pins.
// Counter-to-pin latency PIXEL_LATENCY+2 clocks; renderer must answer every request, no backpressure.
module vga_scanout #(
  parameter int H_ACTIVE      = vga_scanout_pkg::H_ACTIVE,
  parameter int H_FRONT       = vga_scanout_pkg::H_FRONT,
  parameter int H_SYNC        = vga_scanout_pkg::H_SYNC,
  parameter int H_BACK        = vga_scanout_pkg::H_BACK,
  parameter int V_ACTIVE      = vga_scanout_pkg::V_ACTIVE,
  parameter int V_FRONT       = vga_scanout_pkg::V_FRONT,
  parameter int V_SYNC        = vga_scanout_pkg::V_SYNC,
  parameter int V_BACK        = vga_scanout_pkg::V_BACK,
  parameter int TILE_WIDTH    = 32,
  parameter int TILE_HEIGHT   = 32,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  output logic       o_Req_Valid,
  output logic [4:0] o_Tile_X,
  output logic [3:0] o_Tile_Y,
  output logic [4:0] o_Local_X,
  output logic [4:0] o_Local_Y,
  input  logic [8:0] i_Pixel,
  output logic       o_VGA_HSync,
  output logic       o_VGA_VSync,
  output logic [2:0] o_VGA_Red,
  output logic [2:0] o_VGA_Grn,
  output logic [2:0] o_VGA_Blu,
  output logic       o_Frame_Start
);
  import vga_scanout_pkg::*;

  // Tile sizes are powers of two, so divide/modulo reduce to shift/mask.
  localparam int   TX_SHIFT = $clog2(TILE_WIDTH);
  localparam int   TY_SHIFT = $clog2(TILE_HEIGHT);
  localparam cnt_t LX_MASK  = cnt_t'(TILE_WIDTH - 1);
  localparam cnt_t LY_MASK  = cnt_t'(TILE_HEIGHT - 1);

  cnt_t     h_count, v_count;
  vid_ctl_t raw_ctl;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .o_h_count (h_count),
    .o_v_count (v_count),
    .o_ctl     (raw_ctl)
  );

  // Request stage
  vid_ctl_t   req_ctl_q,   req_ctl_d;
  logic [4:0] tile_x_q,    tile_x_d;
  logic [3:0] tile_y_q,    tile_y_d;
  logic [4:0] local_x_q,   local_x_d;
  logic [4:0] local_y_q,   local_y_d;

  always_comb begin
    req_ctl_d = raw_ctl;
    tile_x_d  = '0;
    tile_y_d  = '0;
    local_x_d = '0;
    local_y_d = '0;
    if (raw_ctl.active) begin
      tile_x_d  = 5'(h_count >> TX_SHIFT);
      tile_y_d  = 4'(v_count >> TY_SHIFT);
      local_x_d = 5'(h_count & LX_MASK);
      local_y_d = 5'(v_count & LY_MASK);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      req_ctl_q <= '0;
      tile_x_q  <= '0;
      tile_y_q  <= '0;
      local_x_q <= '0;
      local_y_q <= '0;
    end else begin
      req_ctl_q <= req_ctl_d;
      tile_x_q  <= tile_x_d;
      tile_y_q  <= tile_y_d;
      local_x_q <= local_x_d;
      local_y_q <= local_y_d;
    end
  end

  assign o_Req_Valid = req_ctl_q.active;
  assign o_Tile_X    = tile_x_q;
  assign o_Tile_Y    = tile_y_q;
  assign o_Local_X   = local_x_q;
  assign o_Local_Y   = local_y_q;

  // Control delay line: its tail lines up with the cycle i_Pixel answers the request.
  vid_ctl_t dly_q [PIXEL_LATENCY];
  vid_ctl_t dly_d [PIXEL_LATENCY];

  always_comb begin
    for (int i = 0; i < PIXEL_LATENCY; i++) begin
      dly_d[i] = '0;
    end
    dly_d[0] = req_ctl_q;
    for (int i = 1; i < PIXEL_LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < PIXEL_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIXEL_LATENCY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  // Pin stage
  vid_ctl_t   tail;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [2:0] red_q, red_d;
  logic [2:0] grn_q, grn_d;
  logic [2:0] blu_q, blu_d;
  logic       frame_start_q, frame_start_d;

  assign tail = dly_q[PIXEL_LATENCY-1];

  // The mux keeps an undriven renderer bus from reaching the pins while blanked.
  always_comb begin
    hsync_d       = ~tail.hsync_on;
    vsync_d       = ~tail.vsync_on;
    frame_start_d = tail.frame_start;
    red_d         = '0;
    grn_d         = '0;
    blu_d         = '0;
    if (tail.active) begin
      red_d = i_Pixel[RED_LSB +: CHAN_W];
      grn_d = i_Pixel[GRN_LSB +: CHAN_W];
      blu_d = i_Pixel[BLU_LSB +: CHAN_W];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      red_q         <= '0;
      grn_q         <= '0;
      blu_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      blu_q         <= blu_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_VGA_HSync   = hsync_q;
  assign o_VGA_VSync   = vsync_q;
  assign o_VGA_Red     = red_q;
  assign o_VGA_Grn     = grn_q;
  assign o_VGA_Blu     = blu_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: full-timing instance with a 1-clock renderer, plus reduced-timing
// instances covering PIXEL_LATENCY 2..4 and the full vertical raster.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_low = 0;
  int vs_low = 0;
  bit count_en = 1'b0;

  localparam logic [13:0] PIN_RST = {1'b1, 1'b1, 9'h000, 1'b0};

  // Full-timing instance, PIXEL_LATENCY=1, renderer model below
  logic       r0_vld, r0_hs, r0_vs, r0_fs;
  logic [4:0] r0_tx, r0_lx, r0_ly;
  logic [3:0] r0_ty;
  logic [2:0] r0_r, r0_g, r0_b;
  logic [8:0] pix0;

  vga_scanout #(.PIXEL_LATENCY(1)) u0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_Req_Valid(r0_vld),
    .o_Tile_X(r0_tx), .o_Tile_Y(r0_ty), .o_Local_X(r0_lx), .o_Local_Y(r0_ly),
    .i_Pixel(pix0), .o_VGA_HSync(r0_hs), .o_VGA_VSync(r0_vs),
    .o_VGA_Red(r0_r), .o_VGA_Grn(r0_g), .o_VGA_Blu(r0_b), .o_Frame_Start(r0_fs));

  always @(posedge clk)
    pix0 <= r0_vld ? {r0_tx[2:0], r0_lx[2:0], r0_ly[2:0]} : 9'h1FF;

  // Short lines, full 525-line frame, PIXEL_LATENCY=3
  logic       rv_vld, rv_hs, rv_vs, rv_fs;
  logic [4:0] rv_tx, rv_lx, rv_ly;
  logic [3:0] rv_ty;
  logic [2:0] rv_r, rv_g, rv_b;
  logic [8:0] pix_ones = 9'h1FF;

  vga_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .PIXEL_LATENCY(3)) uv (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_Req_Valid(rv_vld),
    .o_Tile_X(rv_tx), .o_Tile_Y(rv_ty), .o_Local_X(rv_lx), .o_Local_Y(rv_ly),
    .i_Pixel(pix_ones), .o_VGA_HSync(rv_hs), .o_VGA_VSync(rv_vs),
    .o_VGA_Red(rv_r), .o_VGA_Grn(rv_g), .o_VGA_Blu(rv_b), .o_Frame_Start(rv_fs));

  // Tiny frames (16x8 total), PIXEL_LATENCY 2 and 4
  logic       r2_vld, r2_hs, r2_vs, r2_fs, r4_vld, r4_hs, r4_vs, r4_fs;
  logic [4:0] r2_tx, r2_lx, r2_ly, r4_tx, r4_lx, r4_ly;
  logic [3:0] r2_ty, r4_ty;
  logic [2:0] r2_r, r2_g, r2_b, r4_r, r4_g, r4_b;

  vga_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIXEL_LATENCY(2)) u2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_Req_Valid(r2_vld),
    .o_Tile_X(r2_tx), .o_Tile_Y(r2_ty), .o_Local_X(r2_lx), .o_Local_Y(r2_ly),
    .i_Pixel(pix_ones), .o_VGA_HSync(r2_hs), .o_VGA_VSync(r2_vs),
    .o_VGA_Red(r2_r), .o_VGA_Grn(r2_g), .o_VGA_Blu(r2_b), .o_Frame_Start(r2_fs));

  vga_scanout #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIXEL_LATENCY(4)) u4 (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_Req_Valid(r4_vld),
    .o_Tile_X(r4_tx), .o_Tile_Y(r4_ty), .o_Local_X(r4_lx), .o_Local_Y(r4_ly),
    .i_Pixel(pix_ones), .o_VGA_HSync(r4_hs), .o_VGA_VSync(r4_vs),
    .o_VGA_Red(r4_r), .o_VGA_Grn(r4_g), .o_VGA_Blu(r4_b), .o_Frame_Start(r4_fs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request after counter state n: {valid, tile_x, tile_y, local_x, local_y}
  function automatic logic [19:0] req_model(int n, int ht, int ha, int vt, int va);
    int h, v;
    if (n < 0) return '0;
    h = n % ht;
    v = (n / ht) % vt;
    if (h >= ha || v >= va) return '0;
    return {1'b1, 5'(h / 32), 4'(v / 32), 5'(h % 32), 5'(v % 32)};
  endfunction

  // Pins for counter state n: {hsync, vsync, r, g, b, frame_start}
  function automatic logic [13:0] pin_model(int n, int ha, int hf, int hsw, int hb,
                                            int va, int vf, int vsw, int vb, bit enc);
    int h, v, ht, vt;
    logic act, hs, vs, fs;
    logic [8:0] rgb;
    if (n < 0) return PIN_RST;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h = n % ht;
    v = (n / ht) % vt;
    act = (h < ha) && (v < va);
    hs = !(h >= ha + hf && h < ha + hf + hsw);
    vs = !(v >= va + vf && v < va + vf + vsw);
    fs = (h == 0) && (v == 0);
    rgb = !act ? 9'h000 : enc ? {3'(h / 32), 3'(h % 32), 3'(v % 32)} : 9'h1FF;
    return {hs, vs, rgb, fs};
  endfunction

  // Edge m after release: request shows state m-1, pins show state m-(L+2).
  task automatic run_cycles(input int cnt);
    for (int m = 1; m <= cnt; m++) begin
      @(posedge clk);
      @(negedge clk);
      chk("u0_req", {12'b0, r0_vld, r0_tx, r0_ty, r0_lx, r0_ly}, {12'b0, req_model(m - 1, 800, 640, 525, 480)});
      chk("u0_pins", {18'b0, r0_hs, r0_vs, r0_r, r0_g, r0_b, r0_fs},
          {18'b0, pin_model(m - 3, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1)});
      chk("uv_req", {12'b0, rv_vld, rv_tx, rv_ty, rv_lx, rv_ly}, {12'b0, req_model(m - 1, 16, 8, 525, 480)});
      chk("uv_pins", {18'b0, rv_hs, rv_vs, rv_r, rv_g, rv_b, rv_fs},
          {18'b0, pin_model(m - 5, 8, 2, 3, 3, 480, 10, 2, 33, 1'b0)});
      chk("u2_pins", {18'b0, r2_hs, r2_vs, r2_r, r2_g, r2_b, r2_fs},
          {18'b0, pin_model(m - 4, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0)});
      chk("u4_pins", {18'b0, r4_hs, r4_vs, r4_r, r4_g, r4_b, r4_fs},
          {18'b0, pin_model(m - 6, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0)});
      if (count_en && m <= 1600 && !r0_hs) hs_low++;
      if (count_en && !rv_vs) vs_low++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_u0_req", {12'b0, r0_vld, r0_tx, r0_ty, r0_lx, r0_ly}, 32'h0);
    chk("rst_u0_pins", {18'b0, r0_hs, r0_vs, r0_r, r0_g, r0_b, r0_fs}, {18'b0, PIN_RST});
    chk("rst_u4_pins", {18'b0, r4_hs, r4_vs, r4_r, r4_g, r4_b, r4_fs}, {18'b0, PIN_RST});

    // Two full frames of uv, twenty-odd lines of u0
    rst_n = 1'b1;
    count_en = 1'b1;
    run_cycles(17000);
    count_en = 1'b0;
    chk("hsync_low_2lines", hs_low, 192);
    chk("vsync_low_2frames", vs_low, 64);

    // Mid-line reset while u0 is showing a non-black pixel
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_u0_pins", {18'b0, r0_hs, r0_vs, r0_r, r0_g, r0_b, r0_fs}, {18'b0, PIN_RST});
    chk("async_u0_req", {12'b0, r0_vld, r0_tx, r0_ty, r0_lx, r0_ly}, 32'h0);
    chk("async_u2_pins", {18'b0, r2_hs, r2_vs, r2_r, r2_g, r2_b, r2_fs}, {18'b0, PIN_RST});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_uv_pins", {18'b0, rv_hs, rv_vs, rv_r, rv_g, rv_b, rv_fs}, {18'b0, PIN_RST});
    rst_n = 1'b1;
    run_cycles(900);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
